// File: rtl/ext_unit_pipe.sv
// rtl/ext_unit_pipe.sv - pipelined immediate/load-data extender with elastic valid/ready stages
// Optional counters enabled by defining EXT_UNIT_STATS_EN.
module ext_unit_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int STAGES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        ext_op,
    input  logic [IMM_W-1:0]  imm,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [1:0]        byte_off,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              misalign
`ifdef EXT_UNIT_STATS_EN
    ,
    output logic [31:0]       ops_done,
    output logic [15:0]       misalign_cnt
`endif
);

    logic [DATA_W-1:0] ext_res;
    logic              ext_mis;
    logic [1:0]        bsel;
    logic              hsel;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;

    // A 16-bit word has only two byte lanes and one halfword lane.
    always_comb begin
        bsel = byte_off;
        hsel = byte_off[1];
        if (DATA_W == 16) begin
            bsel[1] = 1'b0;
            hsel    = 1'b0;
        end
    end

    assign byte_lane = mem_data[{bsel, 3'b000} +: 8];
    assign half_lane = mem_data[{hsel, 4'b0000} +: 16];

    always_comb begin
        ext_res = '0;
        case (ext_op)
            3'b000:  ext_res = DATA_W'(imm);
            3'b001:  ext_res = DATA_W'($signed(imm));
            3'b010:  ext_res = DATA_W'(imm) << (DATA_W - IMM_W);
            3'b011:  ext_res = DATA_W'($signed(imm)) << 2;
            3'b100:  ext_res = DATA_W'($signed(byte_lane));
            3'b101:  ext_res = DATA_W'(byte_lane);
            3'b110:  ext_res = DATA_W'($signed(half_lane));
            default: ext_res = DATA_W'(half_lane);
        endcase
    end

    assign ext_mis = ext_op[2] & ext_op[1] & byte_off[0];

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] mis_q;
    logic [STAGES-1:0] load;
    logic [DATA_W-1:0] res_q [STAGES];

    // Stage i can load if the consumer drains or any stage from i to the output is empty;
    // written without a stage-to-stage chain so there is no combinational self-reference.
    always_comb begin
        load = '0;
        for (int i = 0; i < STAGES; i++) begin
            load[i] = out_ready | ~&(vld_q | STAGES'((1 << i) - 1));
        end
    end

    assign in_ready  = load[0] | reset;
    assign out_valid = vld_q[STAGES-1];
    assign result    = res_q[STAGES-1];
    assign misalign  = mis_q[STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            mis_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld_q <= '0;
            end else begin
                if (load[0]) begin
                    vld_q[0] <= in_valid;
                end
                for (int i = 1; i < STAGES; i++) begin
                    if (load[i]) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end
            if (load[0] && in_valid) begin
                res_q[0] <= ext_res;
                mis_q[0] <= ext_mis;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (load[i] && vld_q[i-1]) begin
                    res_q[i] <= res_q[i-1];
                    mis_q[i] <= mis_q[i-1];
                end
            end
        end
    end

`ifdef EXT_UNIT_STATS_EN
    // Flush wins over the output handshake, so a squashed entry is never counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_done     <= '0;
            misalign_cnt <= '0;
        end else if (out_valid && out_ready && !flush) begin
            ops_done <= ops_done + 32'd1;
            if (misalign) begin
                misalign_cnt <= misalign_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ext_unit_pipe.sv
// tb/tb_ext_unit_pipe.sv - scoreboard bench for ext_unit_pipe
module tb_ext_unit_pipe;
    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int STAGES = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        ext_op;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] mem_data;
    logic [1:0]        byte_off;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] result;
    logic              misalign;

    ext_unit_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .STAGES(STAGES)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ext_op(ext_op), .imm(imm), .mem_data(mem_data), .byte_off(byte_off),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    int   acc_cnt = 0;
    bit   hold = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = !hold;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        logic        stall;
        logic [31:0] held;
        exp_t        e;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            if (stall && out_valid) check("hold_stable", 64'(result), 64'(held));
            if (out_valid && out_ready && !reset && !flush) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 64'(result), 64'hDEAD_BEEF_DEAD_BEEF);
                end else begin
                    e = sb.pop_front();
                    check("result", 64'(result), 64'(e.res));
                    check("misalign", 64'(misalign), 64'(e.mis));
                    if (e.due >= 0) check("latency", 64'(cyc), 64'(e.due));
                end
            end
            stall = out_valid && !out_ready;
            held  = result;
        end
    end

    task automatic send(input logic [2:0] op, input logic [15:0] im, input logic [31:0] md,
                        input logic [1:0] off, input logic [31:0] er, input logic em, input bit lat);
        exp_t e;
        int   n;
        bit   ok;
        n  = 0;
        ok = 1'b1;
        ext_op = op; imm = im; mem_data = md; byte_off = off; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(in_ready), 64'd1);
                ok = 1'b0;
                break;
            end
        end
        if (ok) begin
            e.res = er;
            e.mis = em;
            e.due = lat ? cyc + STAGES : -1;
            sb.push_back(e);
            acc_cnt++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    task automatic set_hold(input bit h);
        hold = h;
        repeat (2) @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] MW = 32'h80FF7F01;

    initial begin
        int acc0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        ext_op = '0; imm = '0; mem_data = '0; byte_off = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_misalign", 64'(misalign), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        set_hold(1'b0);

        send(3'b000, 16'h8001, 32'h0, 2'd0, 32'h00008001, 1'b0, 1'b1);
        send(3'b001, 16'h8001, 32'h0, 2'd0, 32'hFFFF8001, 1'b0, 1'b1);
        send(3'b010, 16'h8001, 32'h0, 2'd0, 32'h80010000, 1'b0, 1'b1);
        send(3'b011, 16'h8001, 32'h0, 2'd0, 32'hFFFE0004, 1'b0, 1'b1);
        send(3'b001, 16'h7FFF, 32'h0, 2'd0, 32'h00007FFF, 1'b0, 1'b1);
        send(3'b010, 16'h0001, 32'h0, 2'd0, 32'h00010000, 1'b0, 1'b1);
        send(3'b011, 16'h0001, 32'h0, 2'd0, 32'h00000004, 1'b0, 1'b1);
        send(3'b000, 16'hFFFF, MW,    2'd3, 32'h0000FFFF, 1'b0, 1'b1);
        send(3'b011, 16'hFFFF, MW,    2'd1, 32'hFFFFFFFC, 1'b0, 1'b1);
        send(3'b100, 16'h0,    MW,    2'd0, 32'h00000001, 1'b0, 1'b1);
        send(3'b100, 16'h0,    MW,    2'd1, 32'h0000007F, 1'b0, 1'b1);
        send(3'b100, 16'h0,    MW,    2'd2, 32'hFFFFFFFF, 1'b0, 1'b1);
        send(3'b100, 16'h0,    MW,    2'd3, 32'hFFFFFF80, 1'b0, 1'b1);
        send(3'b101, 16'h0,    MW,    2'd2, 32'h000000FF, 1'b0, 1'b1);
        send(3'b101, 16'h0,    MW,    2'd3, 32'h00000080, 1'b0, 1'b1);
        send(3'b110, 16'h0,    MW,    2'd2, 32'hFFFF80FF, 1'b0, 1'b1);
        send(3'b111, 16'h0,    MW,    2'd1, 32'h00007F01, 1'b1, 1'b1);
        send(3'b110, 16'h0,    MW,    2'd3, 32'hFFFF80FF, 1'b1, 1'b1);
        send(3'b110, 16'h0,    MW,    2'd0, 32'h00007F01, 1'b0, 1'b1);
        send(3'b111, 16'h0,    MW,    2'd2, 32'h000080FF, 1'b0, 1'b1);
        wait_drain();

        set_hold(1'b1);
        acc0 = acc_cnt;
        fork
            begin
                send(3'b000, 16'h0011, 32'h0, 2'd0, 32'h00000011, 1'b0, 1'b0);
                send(3'b001, 16'hF022, 32'h0, 2'd0, 32'hFFFFF022, 1'b0, 1'b0);
                send(3'b010, 16'h0033, 32'h0, 2'd0, 32'h00330000, 1'b0, 1'b0);
                send(3'b101, 16'h0,    MW,    2'd1, 32'h0000007F, 1'b0, 1'b0);
                send(3'b111, 16'h0,    MW,    2'd3, 32'h000080FF, 1'b1, 1'b0);
                send(3'b100, 16'h0,    MW,    2'd0, 32'h00000001, 1'b0, 1'b0);
            end
        join_none
        repeat (10) @(negedge clk);
        check("accepted_under_stall", 64'(acc_cnt - acc0), 64'(STAGES));
        check("in_ready_stalled", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        hold = 1'b0;
        wait fork;
        wait_drain();

        set_hold(1'b1);
        send(3'b000, 16'h0101, 32'h0, 2'd0, 32'h00000101, 1'b0, 1'b0);
        send(3'b000, 16'h0202, 32'h0, 2'd0, 32'h00000202, 1'b0, 1'b0);
        send(3'b000, 16'h0303, 32'h0, 2'd0, 32'h00000303, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1; ext_op = 3'b000; imm = 16'h1234;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        set_hold(1'b0);
        send(3'b000, 16'h00AA, 32'h0, 2'd0, 32'h000000AA, 1'b0, 1'b1);
        wait_drain();

        set_hold(1'b1);
        send(3'b001, 16'h8888, 32'h0, 2'd0, 32'hFFFF8888, 1'b0, 1'b0);
        send(3'b001, 16'h9999, 32'h0, 2'd0, 32'hFFFF9999, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_result", 64'(result), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        set_hold(1'b0);
        send(3'b110, 16'h0, MW, 2'd1, 32'h00007F01, 1'b1, 1'b1);
        wait_drain();

        repeat (4) @(negedge clk);
        check("final_empty", 64'(out_valid), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end
endmodule

// File: doc/ext_unit_pipe.md
Name: ext_unit_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle immediate extender. Sits in the ID/EX boundary and the MEM/WB load path.
- Extends immediates in zero, sign, upper and branch-offset modes.
- Also extracts and extends byte/halfword load data from a memory word.
- Elastic valid/ready pipeline of configurable depth, with a flush input for branch/exception squash and misalignment detection.

Parameters:
- IMM_W, 16, immediate field width; 1 < IMM_W < DATA_W.
- DATA_W, 32, result and memory-word width; a multiple of 16 (16, 32 or 64).
- STAGES, 1, number of register stages, 1..4; this is the input-to-output latency in cycles.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all in-flight entries.
- in_valid  in  1  request present.
- in_ready  out  1  stage 0 can accept this cycle.
- ext_op  in  3  operation select (see Behaviour).
- imm  in  IMM_W  immediate field.
- mem_data  in  DATA_W  memory word for load modes.
- byte_off  in  2  byte offset within the word (addr[1:0]).
- out_valid  out  1  result present at the last stage.
- out_ready  in  1  consumer accepts.
- result  out  DATA_W  extended value.
- misalign  out  1  qualifies result; halfword access at an odd offset.

Behaviour:
- Ops:
  - 000 zero-extend imm.
  - 001 sign-extend imm.
  - 010 imm placed in the top bits, low DATA_W-IMM_W bits zero (lui).
  - 011 sign-extend then shift left 2 (branch offset); upper bits truncated to DATA_W.
  - 100 lb: sign-extend byte byte_off of mem_data.
  - 101 lbu: zero-extend that byte.
  - 110 lh: sign-extend halfword byte_off[1].
  - 111 lhu: zero-extend that halfword.
- Byte/halfword lanes are little-endian: byte k = mem_data[8k+7:8k]. For DATA_W=16, byte_off[1] is ignored for byte modes and forced 0 for halfword modes.
- misalign=1 only for ops 110/111 with byte_off[0]=1. In that case the result is still computed from halfword byte_off[1] (byte_off[0] ignored).
- Immediate ops ignore mem_data and byte_off; misalign=0.
- Computation is combinational into stage 0. Stages 1..STAGES-1 are pure registers.
- Each stage holds valid, result and misalign. Stage i loads when it is empty or when stage i+1 (or the consumer, for the last stage) takes its entry this cycle.
  - in_ready = !valid[0] | advance[0]. in_ready is combinational from out_ready through the chain; it does not depend on in_valid.
  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Simultaneous fill and drain on the last stage keeps it full with the new entry: 1 entry/cycle sustained.
- Latency is exactly STAGES cycles with no backpressure.
- While out_valid=1 & out_ready=0, result and misalign hold stable.
- flush:
  - Clears every valid bit next cycle.
  - Any input presented that cycle is discarded; in_ready may still read 1.
  - Flush has priority over load and advance.
  - Data registers need not clear.
- reset: all valid=0, result=0, misalign=0. in_ready=1 from the cycle after reset deasserts; it is also 1 during reset, but any transfer made during reset is discarded.
- Reset or flush mid-stream drops in-flight entries with no partial outputs.
- Data registers update only on load, to save power.

Optional Feature:
- Macro EXT_UNIT_STATS_EN.
- Defined: adds outputs ops_done (32) and misalign_cnt (16).
  - ops_done increments on each output transfer.
  - misalign_cnt increments on each output transfer with misalign=1.
  - Both wrap modulo 2^width and reset to 0 on reset. flush does not clear them. Flushed entries are not counted.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- STAGES=1, imm=16'h8001, ops 000/001/010/011 back-to-back, out_ready=1 -> results 32'h00008001, 32'hFFFF8001, 32'h80010000, 32'hFFFE0004, one per cycle, each 1 cycle after input.
- mem_data=32'h80FF7F01, op 100 at byte_off 0..3 -> 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80. Op 101 at offset 2 -> 32'h000000FF.
- op 110 at byte_off=2 on 32'h80FF7F01 -> 32'hFFFF80FF, misalign=0. Op 111 at byte_off=1 -> 32'h00007F01, misalign=1.
- STAGES=3, stream 6 ops, out_ready held 0 for cycles 4–7:
  - in_ready drops after 3 accepted entries.
  - Output stays stable.
  - All 6 results emerge in order once out_ready=1, none lost or duplicated.
- STAGES=2, pipeline full, assert flush together with in_valid -> out_valid=0 next cycle. The flushed input never appears. The next input emerges after 2 cycles.
- EXT_UNIT_STATS_EN, 10 transfers including 3 misaligned, 2 entries flushed -> ops_done=10, misalign_cnt=3. Reset -> both 0.
